// File: rtl/pipe_stage_buf.sv
// Pipeline stage buffer carrying NUM_CH channels, with flush, stall and a saturating drop counter.
// Optional PIPE_STAGE_SKID_EN selects a two-entry (head + skid) stage with a fully registered in_ready.
module pipe_stage_buf #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic                     flush,
    input  logic                     stall,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [1:0]               occupancy,
    output logic [CNT_W-1:0]         drop_cnt
);
    localparam int unsigned W     = NUM_CH * DATA_W;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [W-1:0]     head_q, head_d;
    logic [1:0]       occ_q, occ_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [SUM_W-1:0] drop_sum;
    logic [1:0]       dropped;
    logic             acc, xfer;
`ifdef PIPE_STAGE_SKID_EN
    logic [W-1:0]     skid_q, skid_d;
`endif

    assign out_valid = (occ_q != 2'd0);
    assign out_data  = head_q;
    assign occupancy = occ_q;
    assign drop_cnt  = drop_q;

`ifdef PIPE_STAGE_SKID_EN
    assign in_ready = !rst && !stall && (occ_q != 2'd2);
`else
    // Single entry: refill in the same cycle the head leaves.
    assign in_ready = !rst && !stall && ((occ_q == 2'd0) || out_ready);
`endif

    // Next-state: flush drops whatever survives this cycle's transfer.
    always_comb begin
        head_d   = head_q;
        occ_d    = occ_q;
        drop_d   = drop_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_d   = skid_q;
`endif
        acc      = in_valid && in_ready && !flush;
        xfer     = out_valid && out_ready;
        dropped  = occ_q - {1'b0, xfer};
        drop_sum = {1'b0, drop_q} + SUM_W'(dropped);

        if (flush) begin
            occ_d  = 2'd0;
            head_d = '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_d = '0;
`endif
            drop_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end else begin
`ifdef PIPE_STAGE_SKID_EN
            // Skid register is kept zero whenever it holds nothing.
            case ({acc, xfer})
                2'b11: head_d = in_data;
                2'b01: begin
                    head_d = skid_q;
                    skid_d = '0;
                    occ_d  = occ_q - 2'd1;
                end
                2'b10: begin
                    if (occ_q == 2'd0) head_d = in_data;
                    else               skid_d = in_data;
                    occ_d = occ_q + 2'd1;
                end
                default: ;
            endcase
`else
            case ({acc, xfer})
                2'b11: head_d = in_data;
                2'b01: begin
                    head_d = '0;
                    occ_d  = 2'd0;
                end
                2'b10: begin
                    head_d = in_data;
                    occ_d  = 2'd1;
                end
                default: ;
            endcase
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            occ_q  <= 2'd0;
            drop_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_q <= '0;
`endif
        end else begin
            head_q <= head_d;
            occ_q  <= occ_d;
            drop_q <= drop_d;
`ifdef PIPE_STAGE_SKID_EN
            skid_q <= skid_d;
`endif
        end
    end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: queue-based reference model checked every cycle plus directed scenarios.
// Honors PIPE_STAGE_SKID_EN the same way as the design.
module tb_pipe_stage_buf;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned W      = NUM_CH * DATA_W;
    localparam int          DMAX   = (1 << CNT_W) - 1;
`ifdef PIPE_STAGE_SKID_EN
    localparam int          CAP    = 2;
`else
    localparam int          CAP    = 1;
`endif

    logic             clk, rst, in_valid, in_ready, flush, stall, out_valid, out_ready;
    logic [W-1:0]     in_data, out_data;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] drop_cnt;

    pipe_stage_buf #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .flush(flush), .stall(stall), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .occupancy(occupancy), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] q[$];
    int drops;
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_rdy();
        if (rst || stall) return 1'b0;
        if (CAP == 2) return q.size() < 2;
        return (q.size() == 0) || out_ready;
    endfunction

    function automatic logic [W-1:0] rep(input int v);
        logic [W-1:0] d;
        for (int c = 0; c < int'(NUM_CH); c++) d[c*DATA_W +: DATA_W] = DATA_W'(v);
        return d;
    endfunction

    function automatic logic [W-1:0] rnd_data();
        logic [W-1:0] d;
        for (int c = 0; c < int'(NUM_CH); c++) d[c*DATA_W +: DATA_W] = DATA_W'($urandom);
        return d;
    endfunction

    task automatic compare();
        chk("out_valid", W'(out_valid), W'(q.size() != 0));
        chk("out_data", out_data, (q.size() != 0) ? q[0] : '0);
        chk("occupancy", W'(occupancy), W'(q.size()));
        chk("drop_cnt", W'(drop_cnt), W'(drops));
        chk("in_ready", W'(in_ready), W'(exp_rdy()));
    endtask

    // Reference behaviour at a rising edge, from the sampled inputs.
    task automatic model_edge();
        bit x, a;
        int n;
        if (rst) begin
            q.delete();
            drops = 0;
        end else begin
            x = (q.size() != 0) && out_ready;
            a = in_valid && exp_rdy() && !flush;
            if (flush) begin
                n = drops + q.size() - int'(x);
                drops = (n > DMAX) ? DMAX : n;
                q.delete();
            end else begin
                if (x) void'(q.pop_front());
                if (a) q.push_back(in_data);
            end
        end
    endtask

    task automatic tick();
        #1 compare();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; in_valid = 0; flush = 0; stall = 0; out_ready = 0; in_data = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic fill();
        idle();
        in_valid = 1;
        for (int k = 0; k < 6; k++) begin
            if (q.size() < CAP) begin
                in_data = rnd_data();
                tick();
            end
        end
        in_valid = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        q.delete();
        drops = 0;
        @(negedge clk);

        // Reset: entry offered during reset is not accepted
        in_valid = 1; in_data = rep(32'h77);
        tick();
        idle();
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_occupancy", W'(occupancy), W'(0));
        chk("rst_drop_cnt", W'(drop_cnt), W'(0));
        chk("rst_out_data", out_data, '0);

        // Streaming with downstream always ready
        out_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1; in_data = rep(i * 32'h11);
            tick();
            chk("stream_data", out_data, rep(i * 32'h11));
            chk("stream_valid", W'(out_valid), W'(1));
        end
        in_valid = 0;
        tick();
        chk("stream_empty", W'(out_valid), W'(0));

        // Backpressure: offer 3 with out_ready low
        do_reset();
        idle();
        in_valid = 1;
        for (int k = 0; k < 3; k++) begin
            in_data = rep(32'h100 + k);
            tick();
        end
        chk("bp_occupancy", W'(occupancy), W'(CAP));
        #1 chk("bp_in_ready", W'(in_ready), W'(0));
        in_valid = 0; out_ready = 1;
        for (int k = 0; k < CAP; k++) begin
            chk("bp_order", out_data, rep(32'h100 + k));
            tick();
        end
        chk("bp_drained", W'(out_valid), W'(0));

        // Flush when full, with a coincident offer
        do_reset();
        fill();
        flush = 1; in_valid = 1; in_data = rep(32'hBAD);
        tick();
        idle();
        chk("flush_valid", W'(out_valid), W'(0));
        chk("flush_occ", W'(occupancy), W'(0));
        chk("flush_data", out_data, '0);
        chk("flush_drops", W'(drop_cnt), W'(CAP));
        tick();
        chk("flush_no_ghost", W'(out_valid), W'(0));

        // Stall with one held entry draining
        do_reset();
        idle();
        in_valid = 1; in_data = rep(32'h55);
        tick();
        stall = 1; out_ready = 1; in_data = rep(32'h66);
        for (int k = 0; k < 3; k++) begin
            #1 chk("stall_in_ready", W'(in_ready), W'(0));
            tick();
        end
        idle();
        chk("stall_valid", W'(out_valid), W'(0));
        chk("stall_data", out_data, '0);
        chk("stall_occ", W'(occupancy), W'(0));

        // Drop counter saturation
        do_reset();
        for (int g = 0; g < 40 && drops < DMAX - 1; g++) begin
            fill();
            flush = 1;
            tick();
            flush = 0;
        end
        chk("sat_preload", W'(drop_cnt), W'(DMAX - 1));
        for (int r = 0; r < 2; r++) begin
            fill();
            flush = 1;
            tick();
            flush = 0;
            chk("sat_hold", W'(drop_cnt), W'(DMAX));
        end

        // Reset while full: entries vanish and are not counted
        do_reset();
        fill();
        rst = 1; in_valid = 1; out_ready = 1;
        tick();
        idle();
        chk("rfull_valid", W'(out_valid), W'(0));
        chk("rfull_occ", W'(occupancy), W'(0));
        chk("rfull_data", out_data, '0);
        chk("rfull_drops", W'(drop_cnt), W'(0));

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 127) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            stall     = ($urandom_range(0, 3) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = rnd_data();
            tick();
        end
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
